// File: rtl/btn_event_gen.sv
// Per-button press/release/auto-repeat pulse generator with a lowest-index
// priority encoder that merges press and repeat events into one keypress stream.
module btn_event_gen #(
  parameter int              NBTN          = 5,
  parameter int              HOLD_CYCLES   = 25000000,
  parameter int              REPEAT_CYCLES = 10000000,
  parameter logic [NBTN-1:0] REPEAT_EN     = NBTN'(5'b00011),
  localparam int             CODE_W        = (NBTN > 1) ? $clog2(NBTN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NBTN-1:0]   btn_in,
  output logic [NBTN-1:0]   press,
  output logic [NBTN-1:0]   rel,
  output logic [NBTN-1:0]   rpt,
  output logic              evt_valid,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_rpt,
  output logic              evt_drop
);

  localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC);

  typedef enum logic [2:0] {
    S_LOCK,
    S_IDLE,
    S_DELAY,
    S_REPEAT,
    S_HELD
  } state_t;

  state_t            state_q [NBTN];
  state_t            state_d [NBTN];
  logic [CNT_W-1:0]  cnt_q   [NBTN];
  logic [CNT_W-1:0]  cnt_d   [NBTN];
  logic [NBTN-1:0]   press_q, press_d;
  logic [NBTN-1:0]   rel_q,   rel_d;
  logic [NBTN-1:0]   rpt_q,   rpt_d;
  logic [NBTN-1:0]   evt_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBTN; i++) begin
        state_q[i] <= S_LOCK;
        cnt_q[i]   <= '0;
      end
      press_q <= '0;
      rel_q   <= '0;
      rpt_q   <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
    end
  end

  // A fall always wins over count expiry, so a release is never paired with a repeat.
  always_comb begin
    press_d = '0;
    rel_d   = '0;
    rpt_d   = '0;
    for (int i = 0; i < NBTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_LOCK: begin
          if (!btn_in[i]) state_d[i] = S_IDLE;
        end
        S_IDLE: begin
          if (btn_in[i]) begin
            state_d[i] = S_DELAY;
            cnt_d[i]   = '0;
            press_d[i] = 1'b1;
          end
        end
        S_DELAY: begin
          if (!btn_in[i]) begin
            state_d[i] = S_IDLE;
            rel_d[i]   = 1'b1;
          end else if (cnt_q[i] == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt_d[i] = '0;
            if (REPEAT_EN[i]) begin
              state_d[i] = S_REPEAT;
              rpt_d[i]   = 1'b1;
            end else begin
              state_d[i] = S_HELD;
            end
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        S_REPEAT: begin
          if (!btn_in[i]) begin
            state_d[i] = S_IDLE;
            rel_d[i]   = 1'b1;
          end else if (cnt_q[i] == CNT_W'(REPEAT_CYCLES - 1)) begin
            cnt_d[i] = '0;
            rpt_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        S_HELD: begin
          if (!btn_in[i]) begin
            state_d[i] = S_IDLE;
            rel_d[i]   = 1'b1;
          end
        end
        default: state_d[i] = S_LOCK;
      endcase
    end
  end

  assign press   = press_q;
  assign rel     = rel_q;
  assign rpt     = rpt_q;
  assign evt_vec = press_q | rpt_q;

  // Scan downward so the lowest-numbered active button is the last one written.
  always_comb begin
    evt_code = '0;
    evt_rpt  = 1'b0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (evt_vec[i]) begin
        evt_code = CODE_W'(i);
        evt_rpt  = rpt_q[i];
      end
    end
  end

  assign evt_valid = |evt_vec;
  assign evt_drop  = |(evt_vec & (evt_vec - NBTN'(1)));

endmodule

// File: tb/tb_btn_event_gen.sv
// Randomized and directed bench for btn_event_gen, checked cycle by cycle
// against a press-age reference model.
module tb_btn_event_gen;

  localparam int         NBTN = 5;
  localparam int         HOLD = 8;
  localparam int         REP  = 4;
  localparam logic [4:0] REN  = 5'b00011;

  logic       clk;
  logic       rst_n;
  logic [4:0] btn_in;
  logic [4:0] press, rel, rpt;
  logic       evt_valid, evt_rpt, evt_drop;
  logic [2:0] evt_code;

  int checks   = 0;
  int failures = 0;

  // Model state: locked until a low level is seen, active while a press is
  // outstanding, age = edges since the press edge.
  bit         m_locked [NBTN];
  bit         m_active [NBTN];
  int         m_age    [NBTN];
  logic [4:0] e_press, e_rel, e_rpt;

  btn_event_gen #(
    .NBTN(NBTN), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .REPEAT_EN(REN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .press(press), .rel(rel), .rpt(rpt),
    .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_rpt(evt_rpt), .evt_drop(evt_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NBTN; i++) begin
      m_locked[i] = 1'b1;
      m_active[i] = 1'b0;
      m_age[i]    = 0;
    end
    e_press = '0;
    e_rel   = '0;
    e_rpt   = '0;
  endtask

  task automatic model_edge(input logic [4:0] b);
    e_press = '0;
    e_rel   = '0;
    e_rpt   = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (m_locked[i]) begin
        if (!b[i]) m_locked[i] = 1'b0;
      end else if (!m_active[i]) begin
        if (b[i]) begin
          e_press[i]  = 1'b1;
          m_active[i] = 1'b1;
          m_age[i]    = 0;
        end
      end else if (!b[i]) begin
        e_rel[i]    = 1'b1;
        m_active[i] = 1'b0;
      end else begin
        m_age[i]++;
        if (REN[i] && m_age[i] >= HOLD && ((m_age[i] - HOLD) % REP) == 0)
          e_rpt[i] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [4:0] ev;
    logic [2:0] code;
    logic       erpt;
    ev   = e_press | e_rpt;
    code = '0;
    erpt = 1'b0;
    for (int i = 0; i < NBTN; i++) begin
      if (ev[i]) begin
        code = 3'(i);
        erpt = e_rpt[i];
        break;
      end
    end
    check("press",     32'(press),     32'(e_press));
    check("release",   32'(rel),       32'(e_rel));
    check("rpt",       32'(rpt),       32'(e_rpt));
    check("evt_valid", 32'(evt_valid), 32'(ev != 0));
    check("evt_code",  32'(evt_code),  32'(code));
    check("evt_rpt",   32'(evt_rpt),   32'(erpt));
    check("evt_drop",  32'(evt_drop),  32'($countones(ev) > 1));
  endtask

  task automatic step(input logic [4:0] b);
    btn_in = b;
    @(posedge clk);
    model_edge(b);
    #1;
    check_outputs();
  endtask

  // Reset lands mid-cycle so an immediate clear proves it is asynchronous.
  task automatic do_reset(input logic [4:0] b);
    btn_in = b;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] b;
    rst_n  = 1'b0;
    btn_in = '0;
    model_reset();
    #13;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Release from reset, then a short press on button 2.
    for (int c = 0; c < 2; c++) step(5'b00000);
    for (int c = 0; c < 3; c++) step(5'b00100);
    for (int c = 0; c < 3; c++) step(5'b00000);

    // Long hold on a repeating button and on a press/release-only button.
    for (int c = 0; c < 30; c++) step(5'b00001);
    for (int c = 0; c < 3; c++) step(5'b00000);
    for (int c = 0; c < 30; c++) step(5'b10000);
    for (int c = 0; c < 3; c++) step(5'b00000);

    // Simultaneous presses, then a one-cycle glitch.
    for (int c = 0; c < 3; c++) step(5'b01010);
    step(5'b00000);
    step(5'b01000);
    step(5'b00000);
    step(5'b00000);

    // Button held through reset stays silent until released.
    for (int c = 0; c < 3; c++) step(5'b00001);
    do_reset(5'b00001);
    for (int c = 0; c < 5; c++) step(5'b00001);
    for (int c = 0; c < 2; c++) step(5'b00000);
    for (int c = 0; c < 3; c++) step(5'b00001);
    step(5'b00000);

    // Reset while button 1 is in its repeat phase, on the cycle a repeat fires.
    for (int c = 0; c < 9; c++) step(5'b00010);
    check("rpt_before_reset", 32'(rpt), 32'h2);
    do_reset(5'b00010);
    for (int c = 0; c < 3; c++) step(5'b00000);

    // Random levels: sparse toggles give long holds, with occasional resets.
    b = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NBTN; i++)
        if ($urandom_range(0, 13) == 0) b[i] = ~b[i];
      if ($urandom_range(0, 399) == 0) do_reset(b);
      step(b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
